// File: rtl/accum_seq_pkg.sv
// Shared types and defaults for the accum_seq pass sequencer.
package accum_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int CNT_W_DEF = 6;

endpackage

// File: rtl/term_counter.sv
// Count register with latched terminal value and wrap-to-zero on terminal advance.
// Load, clear and advance take effect on the next edge; hit is combinational.
module term_counter
  import accum_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clr,
  input  logic             adv,
  input  logic [CNT_W-1:0] len,
  output logic [CNT_W-1:0] count,
  output logic             hit
);

  logic [CNT_W-1:0] term;

  assign hit = (count == term);

  // Load has priority; the FSM never asserts load together with clr or adv.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      term  <= '0;
    end else if (load) begin
      count <= '0;
      term  <= len - CNT_W'(1);
    end else if (clr) begin
      count <= '0;
    end else if (adv) begin
      count <= hit ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/accum_seq.sv
// Pass sequencer: counts 0..len-1 while en is high, one-shot or continuous.
// sum_finish lands len enabled edges after start; en=0 stalls, abort wins over everything.
module accum_seq
  import accum_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter bit CONT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             en,
  input  logic             abort,
  output logic [CNT_W-1:0] count_out,
  output logic             busy,
  output logic             last,
  output logic             sum_finish,
  output logic             len_err
);

  state_t state, state_nxt;
  logic   load, clr, adv, hit;
  logic   fin_nxt, err_nxt;

  term_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .clr   (clr),
    .adv   (adv),
    .len   (len),
    .count (count_out),
    .hit   (hit)
  );

  assign busy = (state == RUN);
  assign last = busy && hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sum_finish <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      sum_finish <= fin_nxt;
      len_err    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    clr       = 1'b0;
    adv       = 1'b0;
    fin_nxt   = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (len != '0) begin
            load      = 1'b1;
            state_nxt = RUN;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          clr       = 1'b1;
          state_nxt = IDLE;
        end else if (en) begin
          adv = 1'b1;
          if (hit) begin
            fin_nxt = 1'b1;
            if (!CONT) state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_accum_seq.sv
// Directed self-checking bench: one-shot instance plus a continuous-mode instance.
module tb_accum_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start_c;
  logic [5:0] len;
  logic       en;
  logic       abort, abort_c;
  logic [5:0] count_out, count_c;
  logic       busy, last, sum_finish, len_err;
  logic       busy_c, last_c, sum_c, err_c;

  int tests = 0;
  int fails = 0;

  accum_seq #(.CNT_W(6), .CONT(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .en(en), .abort(abort),
    .count_out(count_out), .busy(busy), .last(last),
    .sum_finish(sum_finish), .len_err(len_err)
  );

  accum_seq #(.CNT_W(6), .CONT(1'b1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .len(len), .en(en), .abort(abort_c),
    .count_out(count_c), .busy(busy_c), .last(last_c),
    .sum_finish(sum_c), .len_err(err_c)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; start_c = 0; len = 0; en = 1; abort = 0; abort_c = 0;
    tick(); tick();
    tests++;
    if (count_out !== 6'd0 || busy !== 1'b0 || last !== 1'b0 || sum_finish !== 1'b0 || len_err !== 1'b0) begin
      fails++;
      $display("FAIL reset: cnt=%0d busy=%b last=%b fin=%b err=%b, want all 0", count_out, busy, last, sum_finish, len_err);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0 || count_out !== 6'd0) begin
      fails++;
      $display("FAIL reset_release: busy=%b cnt=%0d, want 0 0", busy, count_out);
    end
  endtask

  task automatic test_len50();
    len = 6'd50; start = 1; en = 1;
    tick();
    start = 0;
    len = 6'd3;  // must not affect the running pass
    tests++;
    if (busy !== 1'b1 || count_out !== 6'd0 || last !== 1'b0) begin
      fails++;
      $display("FAIL len50_start: busy=%b cnt=%0d last=%b, want 1 0 0", busy, count_out, last);
    end
    for (int i = 1; i <= 49; i++) begin
      start = (i == 10);
      tick();
      tests++;
      if (count_out !== 6'(i) || sum_finish !== 1'b0 || busy !== 1'b1 || last !== (i == 49)) begin
        fails++;
        $display("FAIL len50_run%0d: cnt=%0d fin=%b busy=%b last=%b", i, count_out, sum_finish, busy, last);
      end
    end
    start = 0;
    tick();
    tests++;
    if (sum_finish !== 1'b1 || busy !== 1'b0 || count_out !== 6'd0 || last !== 1'b0) begin
      fails++;
      $display("FAIL len50_done: fin=%b busy=%b cnt=%0d last=%b, want 1 0 0 0", sum_finish, busy, count_out, last);
    end
    tick();
    tests++;
    if (sum_finish !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL len50_after: fin=%b busy=%b, want 0 0", sum_finish, busy);
    end
  endtask

  task automatic test_stall();
    int n;
    bit seen;
    len = 6'd8; start = 1; en = 1;
    tick();
    start = 0;
    n = 0;
    repeat (4) begin tick(); n++; end
    tests++;
    if (count_out !== 6'd4) begin
      fails++;
      $display("FAIL stall_pre: cnt=%0d, want 4", count_out);
    end
    en = 0;
    for (int k = 0; k < 3; k++) begin
      tick(); n++;
      tests++;
      if (count_out !== 6'd4 || sum_finish !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL stall_hold%0d: cnt=%0d fin=%b busy=%b, want 4 0 1", k, count_out, sum_finish, busy);
      end
    end
    en = 1;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick(); n++;
      if (sum_finish === 1'b1) seen = 1;
    end
    tests++;
    if (!seen || n !== 11) begin
      fails++;
      $display("FAIL stall_latency: seen=%b edges=%0d, want 1 11", seen, n);
    end
  endtask

  task automatic test_len_err();
    len = 6'd0; start = 1;
    tick();
    start = 0;
    tests++;
    if (len_err !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL len_err_pulse: err=%b busy=%b, want 1 0", len_err, busy);
    end
    tick();
    tests++;
    if (len_err !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL len_err_clear: err=%b busy=%b, want 0 0", len_err, busy);
    end
  endtask

  task automatic test_len1();
    len = 6'd1; start = 1; en = 1;
    tick();
    start = 0;
    tests++;
    if (busy !== 1'b1 || last !== 1'b1 || count_out !== 6'd0) begin
      fails++;
      $display("FAIL len1_run: busy=%b last=%b cnt=%0d, want 1 1 0", busy, last, count_out);
    end
    tick();
    tests++;
    if (sum_finish !== 1'b1 || busy !== 1'b0 || last !== 1'b0) begin
      fails++;
      $display("FAIL len1_done: fin=%b busy=%b last=%b, want 1 0 0", sum_finish, busy, last);
    end
    start_c = 1;
    tick();
    start_c = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (sum_c !== 1'b1 || last_c !== 1'b1 || busy_c !== 1'b1 || count_c !== 6'd0) begin
        fails++;
        $display("FAIL len1_cont%0d: fin=%b last=%b busy=%b cnt=%0d, want 1 1 1 0", k, sum_c, last_c, busy_c, count_c);
      end
    end
    abort_c = 1;
    tick();
    abort_c = 0;
  endtask

  task automatic test_cont();
    len = 6'd8; en = 1; start_c = 1;
    tick();
    start_c = 0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      tests++;
      if (count_c !== 6'(k % 8) || sum_c !== (k % 8 == 0) || busy_c !== 1'b1) begin
        fails++;
        $display("FAIL cont_k%0d: cnt=%0d fin=%b busy=%b, want %0d %b 1", k, count_c, sum_c, busy_c, k % 8, (k % 8 == 0));
      end
    end
    abort_c = 1;
    tick();
    abort_c = 0;
    tests++;
    if (busy_c !== 1'b0 || count_c !== 6'd0 || sum_c !== 1'b0) begin
      fails++;
      $display("FAIL cont_abort: busy=%b cnt=%0d fin=%b, want 0 0 0", busy_c, count_c, sum_c);
    end
  endtask

  task automatic test_abort();
    len = 6'd50; en = 1; start = 1;
    tick();
    start = 0;
    repeat (30) tick();
    tests++;
    if (count_out !== 6'd30) begin
      fails++;
      $display("FAIL abort_pre: cnt=%0d, want 30", count_out);
    end
    abort = 1;
    tick();
    abort = 0;
    tests++;
    if (busy !== 1'b0 || count_out !== 6'd0 || sum_finish !== 1'b0) begin
      fails++;
      $display("FAIL abort_mid: busy=%b cnt=%0d fin=%b, want 0 0 0", busy, count_out, sum_finish);
    end
    tick();
    tests++;
    if (sum_finish !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_mid_after: fin=%b busy=%b, want 0 0", sum_finish, busy);
    end
    len = 6'd4; start = 1;
    tick();
    start = 0;
    repeat (3) tick();
    tests++;
    if (count_out !== 6'd3 || last !== 1'b1) begin
      fails++;
      $display("FAIL abort_term_pre: cnt=%0d last=%b, want 3 1", count_out, last);
    end
    abort = 1;
    tick();
    abort = 0;
    tests++;
    if (busy !== 1'b0 || count_out !== 6'd0 || sum_finish !== 1'b0) begin
      fails++;
      $display("FAIL abort_term: busy=%b cnt=%0d fin=%b, want 0 0 0", busy, count_out, sum_finish);
    end
    len = 6'd5; start = 1; abort = 1;
    tick();
    start = 0; abort = 0;
    tests++;
    if (busy !== 1'b0 || len_err !== 1'b0) begin
      fails++;
      $display("FAIL abort_start_idle: busy=%b err=%b, want 0 0", busy, len_err);
    end
  endtask

  task automatic test_async_reset();
    int n;
    bit seen;
    len = 6'd50; en = 1; start = 1;
    tick();
    start = 0;
    repeat (20) tick();
    tests++;
    if (count_out !== 6'd20) begin
      fails++;
      $display("FAIL arst_pre: cnt=%0d, want 20", count_out);
    end
    #2 rst = 1;
    #1;
    tests++;
    if (busy !== 1'b0 || count_out !== 6'd0 || sum_finish !== 1'b0) begin
      fails++;
      $display("FAIL arst_async: busy=%b cnt=%0d fin=%b, want 0 0 0", busy, count_out, sum_finish);
    end
    tick();
    rst = 0;
    tick();
    tests++;
    if (busy !== 1'b0 || sum_finish !== 1'b0) begin
      fails++;
      $display("FAIL arst_release: busy=%b fin=%b, want 0 0", busy, sum_finish);
    end
    len = 6'd8; start = 1;
    tick();
    start = 0;
    n = 0; seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick(); n++;
      if (sum_finish === 1'b1) seen = 1;
    end
    tests++;
    if (!seen || n !== 8 || busy !== 1'b0) begin
      fails++;
      $display("FAIL arst_restart: seen=%b edges=%0d busy=%b, want 1 8 0", seen, n, busy);
    end
  endtask

  initial begin
    test_reset();
    test_len50();
    test_stall();
    test_len_err();
    test_len1();
    test_cont();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
